avmm_sram_responder: RTL and testbench
======================================

AVMM_SRAM_RESPONDER -- requirements
Module: avmm_sram_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, read/write data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 10, word address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width.
REQ-004 SHALL have parameter RD_LAT, default 3, read latency in cycles, legal range 1..8.
REQ-005 SHALL have port clk_clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port avs_address, input, ADDR_W, word address of the first burst beat.
REQ-008 SHALL have port avs_burstcount, input, BURST_W, number of beats in the burst.
REQ-009 SHALL have ports avs_read and avs_write, input, 1 each, command strobes.
REQ-010 SHALL have port avs_writedata, input, DATA_W, write beat data.
REQ-011 SHALL have port avs_byteenable, input, DATA_W/8, per-byte write enables.
REQ-012 SHALL have port avs_waitrequest, output, 1, stall for the presented command or beat.
REQ-013 SHALL have port avs_readdata, output, DATA_W, read beat data.
REQ-014 SHALL have port avs_readdatavalid, output, 1, qualifies avs_readdata.
REQ-015 SHALL have port err_count, output, 8, saturating count of protocol errors.

Function
REQ-016 SHALL act as an Avalon-MM burst slave backed by an internal 2**ADDR_W x DATA_W array, standing in for board SRAM during kernel bring-up.
REQ-017 SHALL implement states IDLE, WR_BURST and RD_BURST.
REQ-018 IDLE: avs_waitrequest=0; write accepted -> beat 0 written at avs_address; go to WR_BURST if burstcount>1, else stay in IDLE.
REQ-019 IDLE: read accepted -> latch address and burstcount; go to RD_BURST; avs_waitrequest=1 from the next cycle.
REQ-020 SHALL treat avs_burstcount=0 as 1 and increment err_count.
REQ-021 SHALL treat avs_read and avs_write asserted together in IDLE as a write only and increment err_count.
REQ-022 WR_BURST: avs_waitrequest=0; each cycle with avs_write=1 writes the next beat at latched address+beat index; avs_write=0 inserts a bubble; return to IDLE after the final beat.
REQ-023 WR_BURST: avs_read=1 SHALL be ignored and SHALL increment err_count.
REQ-024 RD_BURST: SHALL issue one array read per cycle at consecutive addresses; return to IDLE in the cycle after the final issue.
REQ-025 Each read issued in cycle N SHALL appear with avs_readdatavalid=1 in cycle N+RD_LAT; the delay SHALL be an RD_LAT-stage valid/data pipeline.
REQ-026 Beat addresses SHALL wrap modulo 2**ADDR_W (address 2**ADDR_W-1 is followed by 0).
REQ-027 A read of a word written in an earlier cycle SHALL return the written data; there SHALL be no read-during-write hazard within one burst.
REQ-028 err_count SHALL saturate at 255.

Reset
REQ-029 While reset_reset=1: state=IDLE, avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, err_count=0, read pipeline flushed.
REQ-030 Reset mid-burst SHALL abandon the burst; in-flight reads SHALL NOT emerge after reset.
REQ-031 Array contents SHALL be unaffected by reset.
REQ-032 avs_waitrequest SHALL go low in the first cycle after reset_reset deasserts.

Configuration
REQ-033 With macro RESPONDER_BYTEEN_EN defined, a write SHALL update only the bytes whose avs_byteenable bit is 1.
REQ-034 Without RESPONDER_BYTEEN_EN, avs_byteenable SHALL be ignored and every write SHALL update the full word.

Verification
REQ-035 Single write of 0x1122334455667788 to address 5, then burst-1 read of 5 -> readdatavalid exactly RD_LAT cycles after issue, data 0x1122334455667788.
REQ-036 Write burst of 4 beats (0xA0..0xA3) at address 0x3FE with a bubble after beat 1, then read burst of 4 at 0x3FE -> data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles from addresses 0x3FE,0x3FF,0x000,0x001.
REQ-037 With RESPONDER_BYTEEN_EN, write 0xFFFFFFFFFFFFFFFF then 0x0 with byteenable 0x0F to address 7 -> read returns 0xFFFFFFFF00000000; without the macro it returns 0x0.
REQ-038 Assert read and write together, then issue a burstcount=0 read -> err_count=2; the write is performed; the read returns exactly one beat.
REQ-039 Assert reset_reset 2 cycles into an 8-beat read -> no readdatavalid after reset; waitrequest low in the cycle after reset release; earlier-written data still readable.

Source files
------------

// File: rtl/avmm_sram_responder.sv
// Avalon-MM burst slave over an internal word array, used as stand-in board SRAM.
// Optional macro RESPONDER_BYTEEN_EN: honour avs_byteenable on writes (else full-word writes).
module avmm_sram_responder #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 10,
    parameter int BURST_W = 4,
    parameter int RD_LAT  = 3
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [BURST_W-1:0]    avs_burstcount,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [7:0]            err_count
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   left_q, left_d;
    logic [7:0]           err_q, err_d;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;
    logic [BURST_W-1:0]   bc_eff;
    logic                 bc_zero;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic                 rd_issue;

    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic [RD_LAT:1]              vld_pipe_q;
    logic [RD_LAT:1][DATA_W-1:0]  rdata_pipe_q;

    assign bc_zero = (avs_burstcount == '0);
    assign bc_eff  = bc_zero ? BURST_W'(1) : avs_burstcount;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        rd_issue  = 1'b0;
        err_inc   = 2'd0;
        case (state_q)
            IDLE: begin
                if (avs_write) begin
                    // A simultaneous read is dropped; the write wins.
                    mem_we    = 1'b1;
                    mem_waddr = avs_address;
                    err_inc   = {1'b0, avs_read} + {1'b0, bc_zero};
                    if (bc_eff != BURST_W'(1)) begin
                        state_d = WR_BURST;
                        addr_d  = avs_address + ADDR_W'(1);
                        left_d  = bc_eff - BURST_W'(1);
                    end
                end else if (avs_read) begin
                    err_inc = {1'b0, bc_zero};
                    addr_d  = avs_address;
                    left_d  = bc_eff;
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (avs_read) err_inc = 2'd1;
                if (avs_write) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    left_d = left_q - BURST_W'(1);
                    if (left_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                left_d   = left_q - BURST_W'(1);
                if (left_q == BURST_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nothing touches the array or the read pipe while reset is held.
        if (reset_reset) begin
            mem_we   = 1'b0;
            rd_issue = 1'b0;
        end
    end

    assign err_sum = {1'b0, err_q} + {7'd0, err_inc};
    assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset so contents survive a reset pulse.
`ifdef RESPONDER_BYTEEN_EN
    always_ff @(posedge clk_clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs_byteenable[b]) mem_q[mem_waddr][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
    end
`else
    logic unused_be;
    assign unused_be = ^avs_byteenable;

    always_ff @(posedge clk_clk) begin
        if (mem_we) mem_q[mem_waddr] <= avs_writedata;
    end
`endif

    // Stage 1 holds the array word read in the issue cycle; stage RD_LAT drives the port.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vld_pipe_q   <= '0;
            rdata_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_issue;
            if (rd_issue) rdata_pipe_q[1] <= mem_q[addr_q];
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe_q[k]   <= vld_pipe_q[k-1];
                rdata_pipe_q[k] <= rdata_pipe_q[k-1];
            end
        end
    end

    assign avs_waitrequest   = reset_reset | (state_q == RD_BURST);
    assign avs_readdatavalid = ~reset_reset & vld_pipe_q[RD_LAT];
    assign avs_readdata      = reset_reset ? '0 : rdata_pipe_q[RD_LAT];
    assign err_count         = reset_reset ? 8'd0 : err_q;

endmodule

// File: tb/tb_avmm_sram_responder.sv
// Scoreboard bench for avmm_sram_responder: driver queues expected read beats, monitor checks them.
module tb_avmm_sram_responder;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 10;
    localparam int BURST_W = 4;
    localparam int RD_LAT  = 3;

    logic               clk = 1'b0;
    logic               reset_reset;
    logic [ADDR_W-1:0]  avs_address;
    logic [BURST_W-1:0] avs_burstcount;
    logic               avs_read, avs_write;
    logic [DATA_W-1:0]  avs_writedata;
    logic [7:0]         avs_byteenable;
    logic               avs_waitrequest;
    logic [DATA_W-1:0]  avs_readdata;
    logic               avs_readdatavalid;
    logic [7:0]         err_count;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    avmm_sram_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk_clk           (clk),
        .reset_reset       (reset_reset),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .err_count         (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid beat must match the head of the queue in data and cycle.
    always @(negedge clk) begin
        if (avs_readdatavalid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stray_rdv: got data %h at cycle %0d, required no beat", avs_readdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (avs_readdata !== e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL rd_beat: got %h at cycle %0d, required %h at cycle %0d",
                             avs_readdata, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (avs_waitrequest !== 1'b0 && n < 100) begin
            next_cycle();
            n++;
        end
        check("wait_ready", {63'd0, avs_waitrequest}, 64'd0);
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a, input int n, input logic [63:0] base,
                               input int bubble_at, input logic [7:0] be);
        wait_ready();
        avs_address    = a;
        avs_burstcount = BURST_W'(n);
        avs_byteenable = be;
        for (int i = 0; i < n; i++) begin
            if (i == bubble_at) begin
                avs_write = 1'b0;
                check("wr_bubble_wait", {63'd0, avs_waitrequest}, 64'd0);
                next_cycle();
            end
            avs_write     = 1'b1;
            avs_writedata = base + 64'(i);
            next_cycle();
        end
        avs_write = 1'b0;
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc,
                              input logic [63:0] base, input int nexp);
        int t;
        wait_ready();
        avs_read       = 1'b1;
        avs_address    = a;
        avs_burstcount = bc;
        t = cyc;
        for (int i = 0; i < nexp; i++) exp_q.push_back('{data: base + 64'(i), cyc: t + 1 + RD_LAT + i});
        next_cycle();
        avs_read = 1'b0;
        check("rd_waitreq_high", {63'd0, avs_waitrequest}, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            next_cycle();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] be_exp;
        reset_reset    = 1'b1;
        avs_address    = '0;
        avs_burstcount = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '1;

        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_waitreq", {63'd0, avs_waitrequest}, 64'd1);
        check("rst_rdv", {63'd0, avs_readdatavalid}, 64'd0);
        check("rst_rdata", avs_readdata, 64'd0);
        check("rst_err", {56'd0, err_count}, 64'd0);
        next_cycle();
        reset_reset = 1'b0;
        @(negedge clk);
        check("waitreq_after_rst", {63'd0, avs_waitrequest}, 64'd0);

        // Single write then single read, latency checked by the monitor
        write_burst(10'd5, 1, 64'h1122334455667788, -1, 8'hFF);
        read_burst(10'd5, 4'd1, 64'h1122334455667788, 1);
        drain();

        // Wrapping 4-beat write with a bubble, read back across the wrap
        write_burst(10'h3FE, 4, 64'hA0, 2, 8'hFF);
        read_burst(10'h3FE, 4'd4, 64'hA0, 4);
        drain();

        // Partial-byte write
        write_burst(10'd7, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 8'hFF);
        write_burst(10'd7, 1, 64'h0, -1, 8'h0F);
`ifdef RESPONDER_BYTEEN_EN
        be_exp = 64'hFFFF_FFFF_0000_0000;
`else
        be_exp = 64'h0;
`endif
        read_burst(10'd7, 4'd1, be_exp, 1);
        drain();
        check("err_before", {56'd0, err_count}, 64'd0);

        // Read+write together, then a zero-length read
        wait_ready();
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_address    = 10'd20;
        avs_burstcount = 4'd1;
        avs_writedata  = 64'hDEAD_BEEF_0000_0020;
        next_cycle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        read_burst(10'd20, 4'd0, 64'hDEAD_BEEF_0000_0020, 1);
        drain();
        repeat (4) next_cycle();
        check("err_two", {56'd0, err_count}, 64'd2);

        // Reset two cycles into an 8-beat read
        write_burst(10'd100, 8, 64'h5000, -1, 8'hFF);
        read_burst(10'd100, 4'd8, 64'h0, 0);
        next_cycle();
        reset_reset = 1'b1;
        @(negedge clk);
        check("midrst_waitreq", {63'd0, avs_waitrequest}, 64'd1);
        check("midrst_rdv", {63'd0, avs_readdatavalid}, 64'd0);
        next_cycle();
        next_cycle();
        reset_reset = 1'b0;
        @(negedge clk);
        check("waitreq_after_midrst", {63'd0, avs_waitrequest}, 64'd0);
        check("err_after_midrst", {56'd0, err_count}, 64'd0);
        repeat (12) next_cycle();
        read_burst(10'd100, 4'd8, 64'h5000, 8);
        drain();
        read_burst(10'd5, 4'd1, 64'h1122334455667788, 1);
        drain();
        repeat (6) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
